// File: rtl/sa_loader.sv
// sa_loader: collects COLS upstream words per row into a row buffer, issues each
// complete row to the systolic array lanes with its row index, repeats for ROWS
// rows, then holds WRITE through a drain window and a compute window before
// pulsing DONE. The sixteen DOUT lane ports assume COLS = 16.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for START; row/column counters held at 0
// S_FILL    | IN_READY=1, each handshake stores one word of the current row
// S_ISSUE   | one cycle after a full row: lanes/IDX just loaded, IN_READY=0
// S_DRAIN   | WRITE stays 1 for DRAIN_CYCLES after the last row issue
// S_COMPUTE | WRITE=0 for COMPUTE_CYCLES while the array computes
// S_FINISH  | DONE pulse for one cycle, then back to S_IDLE

module sa_loader #(
    parameter int ROWS           = 8,
    parameter int COLS           = 16,
    parameter int DW             = 16,
    parameter int DRAIN_CYCLES   = 2,
    parameter int COMPUTE_CYCLES = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          en,
    output logic          rf_en,
    output logic          write,
    output logic [4:0]    idx,
    output logic [DW-1:0] dout_0,
    output logic [DW-1:0] dout_1,
    output logic [DW-1:0] dout_2,
    output logic [DW-1:0] dout_3,
    output logic [DW-1:0] dout_4,
    output logic [DW-1:0] dout_5,
    output logic [DW-1:0] dout_6,
    output logic [DW-1:0] dout_7,
    output logic [DW-1:0] dout_8,
    output logic [DW-1:0] dout_9,
    output logic [DW-1:0] dout_10,
    output logic [DW-1:0] dout_11,
    output logic [DW-1:0] dout_12,
    output logic [DW-1:0] dout_13,
    output logic [DW-1:0] dout_14,
    output logic [DW-1:0] dout_15,
    output logic          busy,
    output logic          done
);

    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TMAX = (DRAIN_CYCLES > COMPUTE_CYCLES) ? DRAIN_CYCLES : COMPUTE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_DRAIN,
        S_COMPUTE,
        S_FINISH
    } state_t;

    state_t          state;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [TW-1:0]   tmr;
    logic [DW-1:0]   row_buf [COLS];
    logic [DW-1:0]   lane    [COLS];

    // The only combinational output: the loader accepts a word whenever it is filling.
    assign in_ready = (state == S_FILL);

    assign dout_0  = lane[0];
    assign dout_1  = lane[1];
    assign dout_2  = lane[2];
    assign dout_3  = lane[3];
    assign dout_4  = lane[4];
    assign dout_5  = lane[5];
    assign dout_6  = lane[6];
    assign dout_7  = lane[7];
    assign dout_8  = lane[8];
    assign dout_9  = lane[9];
    assign dout_10 = lane[10];
    assign dout_11 = lane[11];
    assign dout_12 = lane[12];
    assign dout_13 = lane[13];
    assign dout_14 = lane[14];
    assign dout_15 = lane[15];

    // Sequencer: state, counters, row buffer and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            col_cnt <= '0;
            row_cnt <= '0;
            tmr     <= '0;
            en      <= 1'b0;
            rf_en   <= 1'b0;
            write   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
            for (int k = 0; k < COLS; k++) begin
                row_buf[k] <= '0;
                lane[k]    <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                    if (start) begin
                        state <= S_FILL;
                        en    <= 1'b1;
                        rf_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        row_buf[col_cnt] <= in_data;
                        if (col_cnt == CW'(COLS - 1)) begin
                            // Final word bypasses the buffer so all lanes load on this edge.
                            for (int k = 0; k < COLS - 1; k++) begin
                                lane[k] <= row_buf[k];
                            end
                            lane[COLS-1] <= in_data;
                            idx          <= 5'(row_cnt);
                            write        <= 1'b1;
                            col_cnt      <= '0;
                            state        <= S_ISSUE;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (row_cnt == RW'(ROWS - 1)) begin
                        tmr   <= TW'(DRAIN_CYCLES - 1);
                        state <= S_DRAIN;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        state   <= S_FILL;
                    end
                end
                S_DRAIN: begin
                    if (tmr == '0) begin
                        tmr   <= TW'(COMPUTE_CYCLES - 1);
                        write <= 1'b0;
                        state <= S_COMPUTE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (tmr == '0) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_FINISH: begin
                    en      <= 1'b0;
                    rf_en   <= 1'b0;
                    busy    <= 1'b0;
                    row_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_loader.sv
// Testbench for sa_loader: random words and valid patterns, checked every cycle
// against a schedule computed from the job rules (row = COLS accepted words,
// then one issue cycle; drain and compute windows; one DONE cycle).

module tb_sa_loader;

    localparam int ROWS    = 8;
    localparam int COLS    = 16;
    localparam int DW      = 16;
    localparam int DRAIN   = 2;
    localparam int COMPUTE = 30;
    localparam int MAXT    = 1200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, en, rf_en, write, busy, done;
    logic [4:0]    idx;
    logic [DW-1:0] dout [COLS];

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_dout [COLS];
    int exp_idx = 0;

    always #5 clk = ~clk;

    sa_loader #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW),
        .DRAIN_CYCLES(DRAIN), .COMPUTE_CYCLES(COMPUTE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .en(en), .rf_en(rf_en), .write(write), .idx(idx),
        .dout_0(dout[0]),   .dout_1(dout[1]),   .dout_2(dout[2]),   .dout_3(dout[3]),
        .dout_4(dout[4]),   .dout_5(dout[5]),   .dout_6(dout[6]),   .dout_7(dout[7]),
        .dout_8(dout[8]),   .dout_9(dout[9]),   .dout_10(dout[10]), .dout_11(dout[11]),
        .dout_12(dout[12]), .dout_13(dout[13]), .dout_14(dout[14]), .dout_15(dout[15]),
        .busy(busy), .done(done)
    );

    // vmode: 0 valid held, 1 toggling 0/1, 2 random. dkind: 0 word=row+1, 1 row0 word=col, 2 random.
    // stray: 0 none, 1 START pulse in first drain cycle, 2 random START pulses while busy.
    // abort_at: cycle at which reset is asserted mid-cycle (-1 for none).
    task automatic run_job(input int vmode, input int dkind, input int stray,
                           input int abort_at, output int fin_out);
        bit            v   [MAXT];
        bit            acc [MAXT];
        int            issue_t [ROWS];
        logic [DW-1:0] words [ROWS*COLS];
        int            t, n, ptr, last, fin;
        bit            is_issue, e_busy, e_write, e_done, e_ready;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (dkind)
                    0:       words[r*COLS+c] = DW'(r + 1);
                    1:       words[r*COLS+c] = (r == 0) ? DW'(c) : DW'($urandom);
                    default: words[r*COLS+c] = DW'($urandom);
                endcase
        for (int i = 0; i < MAXT; i++) begin
            case (vmode)
                0:       v[i] = 1'b1;
                1:       v[i] = (i % 2 == 1);
                default: v[i] = ($urandom_range(0, 3) != 0) || (i >= 600);
            endcase
            acc[i] = 1'b0;
        end
        // Each row needs COLS valid cycles after the previous issue; its issue is the next cycle.
        t = 1;
        for (int r = 0; r < ROWS; r++) begin
            n = 0;
            while (n < COLS) begin
                if (v[t]) begin
                    acc[t] = 1'b1;
                    n++;
                end
                t++;
            end
            issue_t[r] = t;
            t++;
        end
        last = issue_t[ROWS-1];
        fin  = last + DRAIN + COMPUTE + 1;
        ptr  = 0;
        fin_out = fin;

        for (int cy = 0; cy <= fin + 4; cy++) begin
            start = (cy == 0) || (stray == 1 && cy == last + 1) ||
                    (stray == 2 && cy >= 1 && cy <= fin && $urandom_range(0, 7) == 0);
            in_valid = v[cy];
            in_data  = (ptr < ROWS*COLS) ? words[ptr] : DW'($urandom);
            if (cy == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({busy, en, rf_en, write, done, in_ready} !== 6'b0) begin
                    errors++;
                    $display("FAIL abort_ctrl cy=%0d got busy/en/rf_en/write/done/in_ready=%b%b%b%b%b%b exp=000000",
                             cy, busy, en, rf_en, write, done, in_ready);
                end
                checks++;
                if (idx !== 5'd0) begin
                    errors++;
                    $display("FAIL abort_idx cy=%0d got=%0d exp=0", cy, idx);
                end
                for (int k = 0; k < COLS; k++) begin
                    checks++;
                    if (dout[k] !== '0) begin
                        errors++;
                        $display("FAIL abort_dout%0d cy=%0d got=%h exp=0", k, cy, dout[k]);
                    end
                end
                exp_idx = 0;
                for (int k = 0; k < COLS; k++) exp_dout[k] = '0;
                start    = 1'b0;
                in_valid = 1'b0;
                fin_out  = -1;
                return;
            end
            @(negedge clk);
            is_issue = 1'b0;
            for (int r = 0; r < ROWS; r++)
                if (cy == issue_t[r]) begin
                    is_issue = 1'b1;
                    exp_idx  = r;
                    for (int k = 0; k < COLS; k++) exp_dout[k] = words[r*COLS+k];
                end
            e_busy  = (cy >= 1) && (cy <= fin);
            e_write = (cy >= issue_t[0]) && (cy <= last + DRAIN);
            e_done  = (cy == fin);
            e_ready = (cy >= 1) && (cy <= last) && !is_issue;
            checks++;
            if (busy !== e_busy || en !== e_busy || rf_en !== e_busy) begin
                errors++;
                $display("FAIL busy_en cy=%0d got busy/en/rf_en=%b%b%b exp=%b", cy, busy, en, rf_en, e_busy);
            end
            checks++;
            if (write !== e_write) begin
                errors++;
                $display("FAIL write cy=%0d got=%b exp=%b", cy, write, e_write);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL done cy=%0d got=%b exp=%b", cy, done, e_done);
            end
            checks++;
            if (in_ready !== e_ready) begin
                errors++;
                $display("FAIL in_ready cy=%0d got=%b exp=%b", cy, in_ready, e_ready);
            end
            checks++;
            if (idx !== 5'(exp_idx)) begin
                errors++;
                $display("FAIL idx cy=%0d got=%0d exp=%0d", cy, idx, exp_idx);
            end
            for (int k = 0; k < COLS; k++) begin
                checks++;
                if (dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL dout%0d cy=%0d got=%h exp=%h", k, cy, dout[k], exp_dout[k]);
                end
            end
            if (acc[cy]) ptr++;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, en, rf_en, write, done, in_ready} !== 6'b0 || idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got ctrl=%b%b%b%b%b%b idx=%0d exp=0",
                     busy, en, rf_en, write, done, in_ready, idx);
        end
        for (int k = 0; k < COLS; k++) begin
            checks++;
            if (dout[k] !== '0) begin
                errors++;
                $display("FAIL reset_dout%0d got=%h exp=0", k, dout[k]);
            end
        end
        // START and valid words while reset is held must do nothing.
        start = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got busy=%b in_ready=%b exp=0 0", busy, in_ready);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || en !== 1'b0 || write !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset i=%0d got busy/en/write=%b%b%b exp=000", i, busy, en, write);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_job();
        int fin;
        run_job(0, 0, 0, -1, fin);
    endtask

    task automatic test_column_order();
        int fin;
        run_job(0, 1, 0, -1, fin);
    endtask

    task automatic test_gaps();
        int fin;
        run_job(1, 0, 0, -1, fin);
    endtask

    task automatic test_start_while_busy();
        int fin;
        run_job(0, 2, 1, -1, fin);
        run_job(2, 2, 2, -1, fin);
    endtask

    task automatic test_abort();
        int fin;
        // Held valid: row 3 fills from cycle 52, so 5 words are in by the end of cycle 56.
        run_job(0, 2, 0, 57, fin);
        release_reset();
        run_job(0, 2, 0, -1, fin);
    endtask

    task automatic test_reset_mid_job();
        int fin;
        run_job(0, 2, 0, 150, fin);
        release_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL no_restart i=%0d got busy=%b done=%b exp=0 0", i, busy, done);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int fin;
        for (int j = 0; j < 3; j++) run_job(2, 2, 0, -1, fin);
    endtask

    initial begin
        for (int k = 0; k < COLS; k++) exp_dout[k] = '0;
        test_reset();
        test_full_job();
        test_column_order();
        test_gaps();
        test_start_while_busy();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/sa_loader.md
SA_LOADER -- requirements
Module: sa_loader

Interface
REQ-001 Parameter ROWS, 8, number of weight/data rows written per job; IDX SHALL never exceed ROWS-1.
REQ-002 Parameter COLS, 16, words per row (one per DOUT lane).
REQ-003 Parameter DW, 16, word width in bits.
REQ-004 Parameter DRAIN_CYCLES, 2, cycles WRITE stays high after the last row issue, covering the downstream pipeline.
REQ-005 Parameter COMPUTE_CYCLES, 30, cycles with WRITE low while the array computes.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 CLK  in  1  single clock; all state updates on its rising edge.
REQ-008 RST_N  in  1  asynchronous active-low reset.
REQ-009 START  in  1  one-cycle job request; sampled only in IDLE.
REQ-010 IN_VALID  in  1  upstream word valid.
REQ-011 IN_DATA  in  DW  upstream word; column order 0 first.
REQ-012 IN_READY  out  1  loader accepts IN_DATA this cycle.
REQ-013 EN  out  1  systolic array enable.
REQ-014 RF_EN  out  1  array register-file enable.
REQ-015 WRITE  out  1  1 = write row / load phase; 0 = compute phase.
REQ-016 IDX  out  5  row index of the current write.
REQ-017 DOUT_0 .. DOUT_15  out  DW each  row lanes, driving array DIN_0 .. DIN_15.
REQ-018 BUSY  out  1  high in every state except IDLE.
REQ-019 DONE  out  1  one-cycle job-complete pulse.

Function
REQ-020 The FSM SHALL have the states IDLE, FILL, ISSUE, DRAIN, COMPUTE and FINISH.
REQ-021 IDLE: on START=1 go to FILL with the row counter and column counter at 0; all other inputs are ignored.
REQ-022 FILL: IN_READY=1; each handshake (IN_VALID&IN_READY) stores IN_DATA at the column-counter position and increments the column counter.
REQ-023 A FILL cycle with IN_VALID=0 SHALL change nothing; there is no timeout.
REQ-024 On the COLS-th handshake the block SHALL enter ISSUE, loading DOUT_k with word k of the row (the incoming word to DOUT_15), IDX with the row counter and WRITE with 1, all on the same edge.
REQ-025 ISSUE lasts 1 cycle with IN_READY=0.
  - If row < ROWS-1: row+1 and return to FILL.
  - Else: go to DRAIN.
REQ-026 After the first ISSUE, DOUT and IDX SHALL hold the last issued values until the next ISSUE, and WRITE SHALL stay 1 through FILL and DRAIN.
REQ-027 DRAIN SHALL last exactly DRAIN_CYCLES cycles with WRITE=1, then go to COMPUTE.
REQ-028 COMPUTE SHALL last exactly COMPUTE_CYCLES cycles with WRITE=0, then go to FINISH.
REQ-029 FINISH: DONE=1 for 1 cycle, WRITE=0, then IDLE.
REQ-030 EN and RF_EN SHALL be 1 in all states except IDLE, and 0 in IDLE.
REQ-031 All outputs except IN_READY SHALL be registered.
REQ-032 START outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-033 Job latency from START with IN_VALID held at 1 SHALL be ROWS*(COLS+1) + DRAIN_CYCLES + COMPUTE_CYCLES cycles until FINISH, which is 168 cycles at the defaults.
REQ-034 The counters SHALL not wrap: the column counter clears at each ISSUE, and the row counter clears in IDLE.

Reset
REQ-035 While RST_N=0 the block SHALL hold state IDLE.
  - EN, RF_EN, WRITE, BUSY, DONE, IN_READY = 0; IDX = 0; all DOUT = 0; the row buffer and counters = 0.
REQ-036 Reset asserted mid-job SHALL abort immediately, and any partial row SHALL be discarded.
REQ-037 After reset release, the block SHALL remain in IDLE until START.

Verification
REQ-038 Reset: RST_N=0 in COMPUTE -> all outputs 0 in the same cycle; after release, BUSY stays 0 without START.
REQ-039 Full job: START, then 128 words with word = row+1 (1..8 per row) and IN_VALID held at 1 -> the first ISSUE is 17 cycles after START with IDX=0 and all DOUT=1; the last ISSUE has IDX=7 and all DOUT=8; then WRITE=1 for 2 cycles, WRITE=0 for 30 cycles, and one DONE pulse.
REQ-040 Column order: row 0 words 0x0000..0x000F -> DOUT_k = k at the first ISSUE.
REQ-041 Backpressure gaps: IN_VALID toggled 1/0 each cycle -> identical DOUT/IDX sequence, with each ISSUE delayed by the idle cycles only, and no word lost or duplicated.
REQ-042 START while BUSY: pulse START during DRAIN -> no effect; exactly one DONE, then IDLE.
REQ-043 Abort: reset after 5 words of row 3, then START and a fresh job -> the first ISSUE has IDX=0 and the new row 0 data, with no stale words.
